shift_arbiter: RTL and testbench
================================

# shift_arbiter

Shared-shifter controller for the EX stage: arbitrates two requesters for one 32-bit barrel shifter. Requester 0 is the ALU shift path; requester 1 is the load/store byte-alignment path. Uses round-robin arbitration. Performs SLL/SRL/SRA on a single left-shift datapath via bit reversal and a sign-fill mask. Each accepted request produces one registered, ID-tagged result behind a valid/ready output port.

## Interface
- WIDTH, 32, datapath width; fixed at 32, shamt is log2(WIDTH)=5 bits
- clk  in  1  rising-edge clock; the block's only clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  2  per-requester request valid, bit i = requester i
- req_ready  out  2  per-requester grant; a transfer occurs when req_valid[i] && req_ready[i]
- req0_data, req1_data  in  32 each  operand
- req0_shamt, req1_shamt  in  5 each  shift amount
- req0_op, req1_op  in  2 each  00 SLL, 01 SRL, 11 SRA, 10 reserved
- out_valid  out  1  result register holds a result
- out_ready  in  1  consumer accepts the result
- out_data  out  32  shifted result
- out_id  out  1  requester that issued the result
- out_err  out  1  the request used the reserved op

## Operation
- Accept condition: `can_accept = !out_valid || out_ready`. Results drain and refill in the same cycle, giving full throughput.
- Arbitration:
  - One grant per cycle, and only when `can_accept` holds.
  - If exactly one request is valid, that requester is granted.
  - If both are valid, the requester named by priority pointer `ptr` wins.
  - After any grant, `ptr` ← the non-granted requester index.
  - `ptr` is unchanged on idle cycles.
- `req_ready` is a combinational function of `req_valid`, `ptr`, `out_valid` and `out_ready`. It is never asserted to a non-valid requester.
- Datapath for the granted request (combinational, single shifter instance):
  - SLL: `res = shl(data, shamt)`.
  - SRL: `res = rev(shl(rev(data), shamt))`.
  - SRA: SRL result OR'd with `fill`. `fill` = top `shamt` bits set when `data[31]`=1, else 0. `fill` comes from a thermometer decode of `shamt`, not a second shifter.
  - shamt=0: `res = data` for every valid op.
  - Reserved op (10): `res = 0` and `out_err = 1`; the request is otherwise handled normally (granted, counted, pointer updated).
- On accept: `out_data ← res`, `out_id ← granted index`, `out_err ← reserved`, `out_valid ← 1`.
- If `out_valid && out_ready && no grant`: `out_valid ← 0`. `out_data`, `out_id` and `out_err` hold their last values.
- Backpressure: while `out_valid && !out_ready`, all outputs are held stable and `req_ready = 00`.
- Reset:
  - While `reset`=0 at a clock edge: `out_valid=0`, `out_data=0`, `out_id=0`, `out_err=0`, `ptr=0`.
  - Any buffered result is discarded.
  - `req_ready=00` while reset is asserted.

## Timing
- Latency: a request accepted at edge N appears on `out_*` after edge N; `out_valid` is high in cycle N+1.
- Throughput: 1 result per cycle when `out_ready` is held high.
- Fairness: with both requesters continuously valid and no backpressure, grants alternate 0,1,0,1… starting with 0 after reset.
- First cycle after reset release: `ptr=0` and `out_valid=0`, so any valid request is granted immediately.
- Combinational depth per cycle: arbiter, then operand mux and reverse, then a 5-stage mux shifter, then reverse and fill OR, into the register.

## Structure
- Package `shifter_pkg`:
  - `WIDTH` = 32 and `SHAMT_W` = 5.
  - Op enum: `OP_SLL`=2'b00, `OP_SRL`=2'b01, `OP_RSV`=2'b10, `OP_SRA`=2'b11.
  - `rev32` function.
- Sub-module `barrel_shl32`: purely combinational 32-bit left shifter with zero fill. Five mux stages shift by 1/2/4/8/16 under `shamt[0..4]`. Instantiated exactly once in `shift_arbiter`.
- Arbiter, fill decode and result register are inline in `shift_arbiter`.

## Test plan
- SLL: requester 0, `0x00000001`, shamt 31, op 00 → `out_data=0x80000000`, `out_id=0`, `out_err=0`, one cycle later.
- SRL vs SRA: requester 1, `0x80000000`, shamt 4 → SRL gives `0x08000000`; SRA gives `0xF8000000`. SRA of `0x7FFFFFF0`, shamt 4 → `0x07FFFFFF`.
- Contention: both valid every cycle, `out_ready`=1, distinct operands → `req_ready` sequence 01,10,01,10; `out_id` sequence 0,1,0,1; results match per ID.
- Backpressure: `out_ready`=0 for 3 cycles with a result held → `out_*` stable, `req_ready=00`. Then `out_ready`=1 with a request pending → drain and refill in the same cycle, `out_valid` stays 1.
- Reserved op and shamt=0: op 10, data `0xDEADBEEF` → `out_data=0`, `out_err=1`. Op 11, shamt 0, data `0x80000001` → `0x80000001`.
- Reset mid-operation: `out_valid`=1 and `ptr`=1, assert reset for 1 cycle → `out_valid=0`, `out_data=0`. Both requesters then valid → requester 0 granted first.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types and helpers for the EX-stage shared shifter.
package shifter_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_RSV = 2'b10,
        OP_SRA = 2'b11
    } op_e;

    function automatic logic [WIDTH-1:0] rev32(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = d[WIDTH-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/barrel_shl32.sv
// Combinational 32-bit left barrel shifter, zero fill, five log-stages.
module barrel_shl32
    import shifter_pkg::*;
(
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic [WIDTH-1:0]   data_o
);

    logic [SHAMT_W:0][WIDTH-1:0] st;

    assign st[0] = data_i;

    // Stage k shifts by 2^k when shamt bit k is set.
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        assign st[k+1] = shamt_i[k] ? (st[k] << (1 << k)) : st[k];
    end

    assign data_o = st[SHAMT_W];

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter for two requesters sharing one barrel shifter;
// right shifts reuse the left shifter through bit reversal.
module shift_arbiter
    import shifter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [WIDTH-1:0]   req0_data,
    input  logic [WIDTH-1:0]   req1_data,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic [SHAMT_W-1:0] req1_shamt,
    input  logic [1:0]         req0_op,
    input  logic [1:0]         req1_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_id,
    output logic               out_err
);

    logic               ptr_q, ptr_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_id_q, out_id_d;
    logic               out_err_q, out_err_d;

    logic               can_accept;
    logic [1:0]         gnt;
    logic               gnt_any, gnt_idx;

    logic [WIDTH-1:0]   sel_data;
    logic [SHAMT_W-1:0] sel_shamt;
    op_e                sel_op;
    logic [WIDTH-1:0]   shl_in, shl_out, shr, fill, res;

    // Grants are suppressed during reset and whenever the result register is stalled.
    always_comb begin
        can_accept = !out_valid_q || out_ready;
        gnt        = 2'b00;
        if (reset && can_accept) begin
            case (req_valid)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    assign req_ready = gnt;
    assign gnt_any   = |gnt;
    assign gnt_idx   = gnt[1];

    always_comb begin
        sel_data  = gnt_idx ? req1_data  : req0_data;
        sel_shamt = gnt_idx ? req1_shamt : req0_shamt;
        sel_op    = op_e'(gnt_idx ? req1_op : req0_op);
        shl_in    = (sel_op == OP_SLL) ? sel_data : rev32(sel_data);
    end

    barrel_shl32 u_shl (
        .data_i  (shl_in),
        .shamt_i (sel_shamt),
        .data_o  (shl_out)
    );

    // Thermometer decode: the top shamt bits carry the sign for SRA.
    always_comb begin
        shr  = rev32(shl_out);
        fill = '0;
        for (int i = 0; i < WIDTH; i++) begin
            fill[i] = sel_data[WIDTH-1] && ((WIDTH - 1 - i) < int'(sel_shamt));
        end
        case (sel_op)
            OP_SLL:  res = shl_out;
            OP_SRL:  res = shr;
            OP_SRA:  res = shr | fill;
            default: res = '0;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        out_err_d   = out_err_q;
        if (gnt_any) begin
            ptr_d       = ~gnt_idx;
            out_valid_d = 1'b1;
            out_data_d  = res;
            out_id_d    = gnt_idx;
            out_err_d   = (sel_op == OP_RSV);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus random traffic
// against a cycle-level reference model built from the block's rules.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  req_valid, req_ready;
    logic [31:0] req0_data, req1_data;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [1:0]  req0_op, req1_op;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        out_id, out_err;

    shift_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_data  (req0_data),
        .req1_data  (req1_data),
        .req0_shamt (req0_shamt),
        .req1_shamt (req1_shamt),
        .req0_op    (req0_op),
        .req1_op    (req1_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_err    (out_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic        m_valid = 1'b0;
    logic [31:0] m_data  = '0;
    logic        m_id    = 1'b0;
    logic        m_err   = 1'b0;
    logic        m_ptr   = 1'b0;
    logic [1:0]  rdy_exp, rdy_obs;

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                              input logic [1:0] op);
        logic signed [31:0] sd;
        sd = $signed(d);
        case (op)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b11:   return 32'(sd >>> s);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [1:0] model_ready();
        if (!reset || (m_valid && !out_ready)) return 2'b00;
        if (req_valid == 2'b11) return m_ptr ? 2'b10 : 2'b01;
        return req_valid;
    endfunction

    function automatic logic [34:0] model_out();
        return {m_valid, m_data, m_id, m_err};
    endfunction

    // Drive one cycle of inputs, sample req_ready, then advance the model at the edge.
    task automatic cycle(input logic rst, input logic [1:0] v,
                         input logic [31:0] d0, input logic [4:0] s0, input logic [1:0] o0,
                         input logic [31:0] d1, input logic [4:0] s1, input logic [1:0] o1,
                         input logic ordy);
        logic [1:0] g;
        @(negedge clk);
        reset = rst; req_valid = v; out_ready = ordy;
        req0_data = d0; req0_shamt = s0; req0_op = o0;
        req1_data = d1; req1_shamt = s1; req1_op = o1;
        #1;
        rdy_exp = model_ready();
        rdy_obs = req_ready;
        g = rdy_exp;
        @(posedge clk);
        if (!rst) begin
            m_valid = 0; m_data = 0; m_id = 0; m_err = 0; m_ptr = 0;
        end else if (g != 2'b00) begin
            m_id    = g[1];
            m_data  = g[1] ? ref_shift(d1, s1, o1) : ref_shift(d0, s0, o0);
            m_err   = g[1] ? (o1 == 2'b10) : (o0 == 2'b10);
            m_valid = 1'b1;
            m_ptr   = ~g[1];
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(0, 2'b11, 32'h1, 5'd1, 2'b00, 32'h2, 5'd2, 2'b00, 1);
        cycle(0, 2'b11, 32'h1, 5'd1, 2'b00, 32'h2, 5'd2, 2'b00, 1);
        n_chk++;
        if (rdy_obs !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready got %b want 00", rdy_obs);
        end
        n_chk++;
        if ({out_valid, out_data, out_id, out_err} !== 35'h0) begin
            n_fail++; $display("FAIL reset_out got v=%b d=%h id=%b e=%b want all 0",
                               out_valid, out_data, out_id, out_err);
        end
    endtask

    task automatic test_shifts();
        cycle(1, 2'b01, 32'h00000001, 5'd31, 2'b00, 32'h0, 5'd0, 2'b00, 1);
        n_chk++;
        if (rdy_obs !== 2'b01) begin
            n_fail++; $display("FAIL sll_ready got %b want 01", rdy_obs);
        end
        n_chk++;
        if ({out_valid, out_data, out_id, out_err} !== {1'b1, 32'h80000000, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL sll got v=%b d=%h id=%b e=%b want 1 80000000 0 0",
                               out_valid, out_data, out_id, out_err);
        end
        cycle(1, 2'b10, 32'h0, 5'd0, 2'b00, 32'h80000000, 5'd4, 2'b01, 1);
        n_chk++;
        if ({out_valid, out_data, out_id, out_err} !== {1'b1, 32'h08000000, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL srl got d=%h id=%b want 08000000 1", out_data, out_id);
        end
        cycle(1, 2'b10, 32'h0, 5'd0, 2'b00, 32'h80000000, 5'd4, 2'b11, 1);
        n_chk++;
        if (out_data !== 32'hF8000000) begin
            n_fail++; $display("FAIL sra_neg got %h want f8000000", out_data);
        end
        cycle(1, 2'b10, 32'h0, 5'd0, 2'b00, 32'h7FFFFFF0, 5'd4, 2'b11, 1);
        n_chk++;
        if (out_data !== 32'h07FFFFFF) begin
            n_fail++; $display("FAIL sra_pos got %h want 07ffffff", out_data);
        end
    endtask

    task automatic test_contention();
        logic [1:0] want_r[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, b;
            logic [31:0] want_d;
            a = 32'h11110000 + 32'(i);
            b = 32'hA0000000 + 32'(i);
            cycle(1, 2'b11, a, 5'(i + 1), 2'b00, b, 5'(i + 2), 2'b01, 1);
            want_d = want_r[i][1] ? (b >> (i + 2)) : (a << (i + 1));
            n_chk++;
            if (rdy_obs !== want_r[i]) begin
                n_fail++; $display("FAIL contend_ready[%0d] got %b want %b", i, rdy_obs, want_r[i]);
            end
            n_chk++;
            if (out_id !== want_r[i][1] || out_data !== want_d) begin
                n_fail++; $display("FAIL contend_out[%0d] got id=%b d=%h want id=%b d=%h",
                                   i, out_id, out_data, want_r[i][1], want_d);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [34:0] snap;
        snap = {out_valid, out_data, out_id, out_err};
        for (int i = 0; i < 3; i++) begin
            cycle(1, 2'b11, 32'h12345678, 5'd3, 2'b00, 32'h9ABCDEF0, 5'd5, 2'b01, 0);
            n_chk++;
            if (rdy_obs !== 2'b00 || {out_valid, out_data, out_id, out_err} !== snap) begin
                n_fail++; $display("FAIL stall[%0d] got rdy=%b out=%h want rdy=00 out=%h",
                                   i, rdy_obs, {out_valid, out_data, out_id, out_err}, snap);
            end
        end
        cycle(1, 2'b01, 32'h12345678, 5'd3, 2'b00, 32'h0, 5'd0, 2'b00, 1);
        n_chk++;
        if (rdy_obs !== 2'b01 || out_valid !== 1'b1 || out_data !== 32'h91A2B3C0) begin
            n_fail++; $display("FAIL refill got rdy=%b v=%b d=%h want 01 1 91a2b3c0",
                               rdy_obs, out_valid, out_data);
        end
        cycle(1, 2'b00, 32'h0, 5'd0, 2'b00, 32'h0, 5'd0, 2'b00, 1);
        n_chk++;
        if (out_valid !== 1'b0 || out_data !== 32'h91A2B3C0) begin
            n_fail++; $display("FAIL drain got v=%b d=%h want 0 91a2b3c0", out_valid, out_data);
        end
    endtask

    task automatic test_reserved();
        cycle(1, 2'b01, 32'hDEADBEEF, 5'd7, 2'b10, 32'h0, 5'd0, 2'b00, 1);
        n_chk++;
        if ({out_valid, out_data, out_err} !== {1'b1, 32'h0, 1'b1}) begin
            n_fail++; $display("FAIL reserved got v=%b d=%h e=%b want 1 0 1", out_valid, out_data, out_err);
        end
        cycle(1, 2'b01, 32'h80000001, 5'd0, 2'b11, 32'h0, 5'd0, 2'b00, 1);
        n_chk++;
        if ({out_data, out_err} !== {32'h80000001, 1'b0}) begin
            n_fail++; $display("FAIL sra_zero got d=%h e=%b want 80000001 0", out_data, out_err);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1, 2'b01, 32'h5, 5'd1, 2'b00, 32'h0, 5'd0, 2'b00, 1);
        cycle(0, 2'b11, 32'h5, 5'd1, 2'b00, 32'h7, 5'd1, 2'b00, 1);
        n_chk++;
        if (rdy_obs !== 2'b00 || out_valid !== 1'b0 || out_data !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset got rdy=%b v=%b d=%h want 00 0 0", rdy_obs, out_valid, out_data);
        end
        cycle(1, 2'b11, 32'h5, 5'd1, 2'b00, 32'h7, 5'd1, 2'b00, 1);
        n_chk++;
        if (rdy_obs !== 2'b01 || out_id !== 1'b0 || out_data !== 32'hA) begin
            n_fail++; $display("FAIL post_reset got rdy=%b id=%b d=%h want 01 0 0000000a", rdy_obs, out_id, out_data);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) != 0), 2'($urandom), $urandom, 5'($urandom), 2'($urandom),
                  $urandom, 5'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0));
            n_chk++;
            if (rdy_obs !== rdy_exp) begin
                n_fail++; $display("FAIL rand_ready[%0d] got %b want %b", i, rdy_obs, rdy_exp);
            end
            n_chk++;
            if ({out_valid, out_data, out_id, out_err} !== model_out()) begin
                n_fail++; $display("FAIL rand_out[%0d] got %h want %h", i,
                                   {out_valid, out_data, out_id, out_err}, model_out());
            end
        end
    endtask

    initial begin
        reset = 0; req_valid = 0; out_ready = 0;
        req0_data = 0; req0_shamt = 0; req0_op = 0;
        req1_data = 0; req1_shamt = 0; req1_op = 0;
        test_reset();
        test_shifts();
        test_contention();
        test_backpressure();
        test_reserved();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
